router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
- Datapath register stage of the 1x3 router. Sits directly downstream of router_fsm and consumes its state decodes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Latches the header byte, forwards header and payload bytes to the FIFO write bus, and parks one byte when the target FIFO is full.
- Accumulates packet parity and compares it against the trailing parity byte.
- Returns parity_done and low_packet_valid to router_fsm, and drives err to the top level.

Parameters:
- WIDTH, 8, data byte width; the address field is always datain[1:0].
- BAD_ADDR, 2'b11, address value that is never captured as a header.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- packet_valid  in  1  source qualifies datain; falls on the parity byte cycle.
- datain  in  WIDTH  source byte stream: header, payload, then parity.
- fifo_full  in  1  selected FIFO is full this cycle.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR; clears low_packet_valid.
- parity_done  out  1  parity byte captured and packet complete.
- low_packet_valid  out  1  packet_valid fell during LOAD_DATA.
- err  out  1  parity mismatch flag.
- dout  out  WIDTH  byte to FIFO write port.

Behaviour:
- Reset (resetn=0, asynchronous): dout, parity_done, low_packet_valid and err go to 0. Internal registers also go to 0: hdr_byte, full_byte, int_parity, pkt_parity.
- Priority among registered updates: reset first, then detect_add clears, then load actions.
- Header capture: when detect_add=1, packet_valid=1 and datain[1:0]!=BAD_ADDR, hdr_byte<=datain. If datain[1:0]=BAD_ADDR, hdr_byte holds.
- detect_add=1 clears int_parity, pkt_parity, parity_done and err on the same edge.
- dout, evaluated as an exclusive priority list:
  - lfd_state: dout<=hdr_byte.
  - ld_state and !fifo_full: dout<=datain.
  - ld_state and fifo_full: full_byte<=datain; dout holds.
  - laf_state: dout<=full_byte.
  - Otherwise dout holds.
- Latency: datain to dout is 1 clock. The header appears on dout 1 clock after lfd_state is sampled.
- Parity accumulation:
  - lfd_state: int_parity<=int_parity^hdr_byte.
  - ld_state and packet_valid: int_parity^=datain, regardless of fifo_full. A byte parked in full_byte is still counted.
  - full_state or laf_state: no accumulation.
- Parity capture: when ld_state=1 and packet_valid=0, pkt_parity<=datain.
- parity_done set conditions:
  - ld_state and !packet_valid and !fifo_full.
  - laf_state and low_packet_valid and !parity_done.
- parity_done is cleared only by detect_add or reset.
- low_packet_valid:
  - Set when ld_state=1 and packet_valid=0.
  - Cleared when rst_int_reg=1.
  - If set and clear coincide, clear wins.
- err: on any edge where parity_done=1 (registered value), err<=(int_parity!=pkt_parity). It is therefore valid 1 clock after parity_done rises, and holds until detect_add or reset.
- Parity byte while FIFO full: the byte lands in full_byte and pkt_parity together. parity_done is deferred to laf_state.
- FSM decode inputs are one-hot by contract; behaviour with two or more high at once is unspecified.
- Reset mid-packet: all outputs return to 0 immediately. No partial-packet state survives.

Test Plan:
1. Good packet. Stimulus in order:
   - detect_add with datain=8'h05.
   - lfd_state.
   - ld_state with datain=8'h3C, packet_valid=1.
   - ld_state with datain=8'h39, packet_valid=0.
   Required: dout=05, then 3C; pkt_parity=39; parity_done=1 and low_packet_valid=1 after the last edge; err=0 on the next edge.
2. Bad parity: same sequence with a final byte of 8'h00. Required: parity_done=1, then err=1 one clock later, held until the next detect_add, which returns err to 0.
3. FIFO full. Stimulus: ld_state, fifo_full=1, datain=8'hAA; then full_state; then laf_state. Required: dout holds 3C through full_state, becomes AA after laf_state, and int_parity includes AA.
4. Invalid address: detect_add with datain=8'h07 (addr 11). Required: hdr_byte is unchanged, and a following lfd_state drives the previous header onto dout.
5. rst_int_reg=1 with low_packet_valid=1. Required: low_packet_valid=0 next edge while parity_done stays 1. Also drive the set condition in the same cycle as rst_int_reg: low_packet_valid=0.
6. Assert resetn=0 mid-payload between clock edges. Required: dout, parity_done, low_packet_valid and err are 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/router_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : router_reg_if
// Description : Bus between router_fsm/source and the router_reg datapath
//               stage. Carries the source byte stream, FIFO full status, the
//               FSM state decodes and the status/data returned by router_reg.
//               slave  : router_reg side (decodes in, status and dout out)
//               master : driving side (decodes out, status and dout in)
// Revision    : 1.0 - initial release
// ============================================================================
interface router_reg_if #(
    parameter int WIDTH = 8
) ();
    logic             packet_valid;
    logic [WIDTH-1:0] datain;
    logic             fifo_full;
    logic             detect_add;
    logic             lfd_state;
    logic             ld_state;
    logic             laf_state;
    logic             full_state;
    logic             rst_int_reg;
    logic             parity_done;
    logic             low_packet_valid;
    logic             err;
    logic [WIDTH-1:0] dout;

    modport slave (
        input  packet_valid, datain, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output parity_done, low_packet_valid, err, dout
    );

    modport master (
        output packet_valid, datain, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  parity_done, low_packet_valid, err, dout
    );
endinterface
`default_nettype wire

// File: rtl/router_reg.sv
`default_nettype none
// ============================================================================
// Module      : router_reg
// Description : Datapath register stage of the 1x3 router. Latches the header
//               byte, forwards header/payload/parity bytes to the FIFO write
//               bus, parks one byte while the FIFO is full, accumulates the
//               packet parity and flags a mismatch against the parity byte.
// Ports       : clk    - system clock, rising edge
//               resetn - asynchronous active-low reset
//               bus    - router_reg_if.slave (stream in, FSM decodes in,
//                        parity_done / low_packet_valid / err / dout out)
// Revision    : 1.0 - initial release
// ============================================================================
module router_reg #(
    parameter int         WIDTH    = 8,
    parameter logic [1:0] BAD_ADDR = 2'b11
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    router_reg_if.slave bus
);

    logic [WIDTH-1:0] hdr_byte_q,   hdr_byte_d;
    logic [WIDTH-1:0] full_byte_q,  full_byte_d;
    logic [WIDTH-1:0] int_parity_q, int_parity_d;
    logic [WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             parity_done_q, parity_done_d;
    logic             low_pkt_valid_q, low_pkt_valid_d;
    logic             err_q,        err_d;

    always_comb begin
        hdr_byte_d      = hdr_byte_q;
        full_byte_d     = full_byte_q;
        int_parity_d    = int_parity_q;
        pkt_parity_d    = pkt_parity_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        err_d           = err_q;

        // A header carrying the reserved address is never latched, so the
        // previously accepted header stays in place.
        if (bus.detect_add && bus.packet_valid && (bus.datain[1:0] != BAD_ADDR)) begin
            hdr_byte_d = bus.datain;
        end

        // FIFO write data. While the FIFO is full the incoming byte is parked
        // and replayed once the FSM reaches LOAD_AFTER_FULL.
        if (bus.lfd_state) begin
            dout_d = hdr_byte_q;
        end else if (bus.ld_state && !bus.fifo_full) begin
            dout_d = bus.datain;
        end else if (bus.ld_state && bus.fifo_full) begin
            full_byte_d = bus.datain;
        end else if (bus.laf_state) begin
            dout_d = full_byte_q;
        end else if (bus.full_state) begin
            dout_d = dout_q;
        end

        if (bus.detect_add) begin
            int_parity_d  = '0;
            pkt_parity_d  = '0;
            parity_done_d = 1'b0;
            err_d         = 1'b0;
        end else begin
            // Parked bytes are counted when they arrive, not when replayed.
            if (bus.lfd_state) begin
                int_parity_d = int_parity_q ^ hdr_byte_q;
            end else if (bus.ld_state && bus.packet_valid) begin
                int_parity_d = int_parity_q ^ bus.datain;
            end

            // packet_valid low during LOAD_DATA marks the parity byte.
            if (bus.ld_state && !bus.packet_valid) begin
                pkt_parity_d = bus.datain;
            end

            // A parity byte parked behind a full FIFO completes the packet
            // only once it is replayed from LOAD_AFTER_FULL.
            if ((bus.ld_state && !bus.packet_valid && !bus.fifo_full) ||
                (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
                parity_done_d = 1'b1;
            end

            if (parity_done_q) begin
                err_d = (int_parity_q != pkt_parity_q);
            end
        end

        // Clear wins over set.
        if (bus.rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (bus.ld_state && !bus.packet_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hdr_byte_q      <= '0;
            full_byte_q     <= '0;
            int_parity_q    <= '0;
            pkt_parity_q    <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            hdr_byte_q      <= hdr_byte_d;
            full_byte_q     <= full_byte_d;
            int_parity_q    <= int_parity_d;
            pkt_parity_q    <= pkt_parity_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
        end
    end

    assign bus.dout             = dout_q;
    assign bus.parity_done      = parity_done_q;
    assign bus.low_packet_valid = low_pkt_valid_q;
    assign bus.err              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_reg
// Description : Self-checking bench for router_reg. Plays the role of
//               router_fsm and the source, sending whole packets (directed
//               and random) and checking FIFO write data, parity status and
//               error flag against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    router_reg_if #(.WIDTH(8)) bus ();

    router_reg #(
        .WIDTH    (8),
        .BAD_ADDR (2'b11)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: last accepted header plus the packet contents.
    logic [7:0] m_hdr = 8'h00;
    logic [7:0] pl[$];   // payload bytes
    bit         fl[$];   // fifo_full per payload byte, last entry for parity

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.packet_valid = 1'b0;
        bus.datain       = 8'h00;
        bus.fifo_full    = 1'b0;
        bus.detect_add   = 1'b0;
        bus.lfd_state    = 1'b0;
        bus.ld_state     = 1'b0;
        bus.laf_state    = 1'b0;
        bus.full_state   = 1'b0;
        bus.rst_int_reg  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Park then replay: full_state cycles hold dout, laf_state replays exp_byte.
    task automatic full_then_laf(input logic [7:0] prev, input logic [7:0] exp_byte,
                                 input bit exp_pdone);
        int nf;
        nf = int'($urandom_range(1, 2));
        for (int k = 0; k < nf; k++) begin
            idle_inputs();
            bus.full_state = 1'b1;
            step();
            chk("full_hold", bus.dout, prev);
            chk("full_pdone", 8'(bus.parity_done), 8'h00);
        end
        idle_inputs();
        bus.laf_state = 1'b1;
        bus.packet_valid = 1'b1;
        step();
        chk("laf_dout", bus.dout, exp_byte);
        chk("laf_pdone", 8'(bus.parity_done), 8'(exp_pdone));
    endtask

    // Sends header, pl[] and a parity byte. fixed selects fixed_byte as the
    // parity byte, otherwise corrupt selects a wrong or the correct parity.
    // clash drives rst_int_reg together with the parity byte.
    task automatic send_packet(input logic [7:0] hdr, input bit corrupt,
                               input bit fixed, input logic [7:0] fixed_byte,
                               input bit clash);
        logic [7:0] par;
        logic [7:0] prev;
        logic [7:0] pbyte;
        bit         exp_err;
        bit         pfull;

        idle_inputs();
        bus.detect_add   = 1'b1;
        bus.packet_valid = 1'b1;
        bus.datain       = hdr;
        step();
        if (hdr[1:0] != 2'b11) m_hdr = hdr;
        chk("dec_pdone", 8'(bus.parity_done), 8'h00);
        chk("dec_err", 8'(bus.err), 8'h00);

        idle_inputs();
        bus.lfd_state    = 1'b1;
        bus.packet_valid = 1'b1;
        bus.datain       = 8'($urandom);
        step();
        chk("lfd_dout", bus.dout, m_hdr);

        par  = m_hdr;
        prev = m_hdr;
        foreach (pl[i]) begin
            idle_inputs();
            bus.ld_state     = 1'b1;
            bus.packet_valid = 1'b1;
            bus.datain       = pl[i];
            bus.fifo_full    = fl[i];
            step();
            par ^= pl[i];
            if (!fl[i]) begin
                chk("ld_dout", bus.dout, pl[i]);
            end else begin
                chk("ld_full_hold", bus.dout, prev);
                full_then_laf(prev, pl[i], 1'b0);
            end
            prev = pl[i];
        end

        if (fixed)        pbyte = fixed_byte;
        else if (corrupt) pbyte = par ^ 8'($urandom_range(1, 255));
        else              pbyte = par;
        exp_err = (pbyte != par);
        pfull   = fl[pl.size()];

        idle_inputs();
        bus.ld_state    = 1'b1;
        bus.datain      = pbyte;
        bus.fifo_full   = pfull;
        bus.rst_int_reg = clash;
        step();
        if (!pfull) begin
            chk("par_dout", bus.dout, pbyte);
            chk("par_pdone", 8'(bus.parity_done), 8'h01);
            chk("par_lpv", 8'(bus.low_packet_valid), clash ? 8'h00 : 8'h01);
        end else begin
            chk("parf_hold", bus.dout, prev);
            chk("parf_pdone", 8'(bus.parity_done), 8'h00);
            chk("parf_lpv", 8'(bus.low_packet_valid), 8'h01);
            full_then_laf(prev, pbyte, 1'b1);
        end

        idle_inputs();
        bus.rst_int_reg = 1'b1;
        step();
        chk("cpe_err", 8'(bus.err), 8'(exp_err));
        chk("cpe_lpv", 8'(bus.low_packet_valid), 8'h00);
        chk("cpe_pdone", 8'(bus.parity_done), 8'h01);

        idle_inputs();
        step();
        chk("idle_err", 8'(bus.err), 8'(exp_err));
        chk("idle_dout", bus.dout, pbyte);
    endtask

    // Called just after a clock edge: reset lands between edges and must be
    // visible before the next edge.
    task automatic async_reset_check();
        #3;
        resetn = 1'b0;
        #1;
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_pdone", 8'(bus.parity_done), 8'h00);
        chk("rst_lpv", 8'(bus.low_packet_valid), 8'h00);
        chk("rst_err", 8'(bus.err), 8'h00);
        idle_inputs();
        step();
        #2;
        resetn = 1'b1;
        m_hdr  = 8'h00;
    endtask

    initial begin
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        chk("por_dout", bus.dout, 8'h00);
        chk("por_pdone", 8'(bus.parity_done), 8'h00);
        chk("por_lpv", 8'(bus.low_packet_valid), 8'h00);
        chk("por_err", 8'(bus.err), 8'h00);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;

        // Good packet: 05, 3C, parity 39.
        pl = '{8'h3C}; fl = '{1'b0, 1'b0};
        send_packet(8'h05, 1'b0, 1'b1, 8'h39, 1'b0);
        // Bad parity byte 00.
        send_packet(8'h05, 1'b0, 1'b1, 8'h00, 1'b0);
        // FIFO full on AA, parity still covers AA.
        pl = '{8'h3C, 8'hAA}; fl = '{1'b0, 1'b1, 1'b0};
        send_packet(8'h05, 1'b0, 1'b0, 8'h00, 1'b0);
        // Reserved address: previous header 05 reused.
        pl = '{8'h11}; fl = '{1'b0, 1'b0};
        send_packet(8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        // Set and clear of low_packet_valid together.
        pl = '{8'h22}; fl = '{1'b0, 1'b0};
        send_packet(8'h09, 1'b0, 1'b0, 8'h00, 1'b1);
        // Parity byte itself parked behind a full FIFO, corrupted.
        pl = '{8'h5A, 8'h01}; fl = '{1'b1, 1'b0, 1'b1};
        send_packet(8'h12, 1'b1, 1'b0, 8'h00, 1'b0);

        for (int p = 0; p < 40; p++) begin
            int  len;
            bit  clash;
            len = int'($urandom_range(1, 6));
            pl.delete();
            fl.delete();
            for (int b = 0; b <= len; b++) begin
                if (b < len) pl.push_back(8'($urandom));
                fl.push_back($urandom_range(0, 3) == 0);
            end
            clash = !fl[len] && ($urandom_range(0, 4) == 0);
            send_packet(8'($urandom), $urandom_range(0, 1) == 1, 1'b0, 8'h00, clash);
        end

        // Reset after a corrupt packet (err and parity_done high).
        pl = '{8'h77}; fl = '{1'b0, 1'b0};
        send_packet(8'h05, 1'b0, 1'b1, 8'hFF, 1'b0);
        async_reset_check();

        // Reset mid-payload.
        idle_inputs();
        bus.detect_add = 1'b1; bus.packet_valid = 1'b1; bus.datain = 8'h56;
        step();
        idle_inputs();
        bus.lfd_state = 1'b1; bus.packet_valid = 1'b1;
        step();
        idle_inputs();
        bus.ld_state = 1'b1; bus.packet_valid = 1'b1; bus.datain = 8'h9A;
        step();
        chk("pre_rst_dout", bus.dout, 8'h9A);
        async_reset_check();

        // Header register cleared by reset: reserved address replays 00.
        pl = '{8'h44}; fl = '{1'b0, 1'b0};
        send_packet(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
